// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states, ISA fields,
// ALU operations and datapath mux selects.
package mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_I_EXEC    = 4'd8,
        S_IMM_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

    localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_SRA = 6'h03;
    localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2a;

    localparam logic [ALU_W-1:0] ALU_AND = 4'd0;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'd9;

    localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] PC_SRC_REGA   = 2'b11;

    localparam logic [SEL_W-1:0] SRC_A_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRC_A_REGA  = 2'b01;
    localparam logic [SEL_W-1:0] SRC_A_SHAMT = 2'b10;

    localparam logic [SEL_W-1:0] SRC_B_REGB    = 2'b00;
    localparam logic [SEL_W-1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRC_B_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRC_B_IMM_SL2 = 2'b11;

    localparam logic [SEL_W-1:0] REG_DST_RT = 2'b00;
    localparam logic [SEL_W-1:0] REG_DST_RD = 2'b01;
    localparam logic [SEL_W-1:0] REG_DST_RA = 2'b10;

    localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MEM    = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

    // Shift functs (0000xx) take their A operand from the shamt field.
    function automatic logic is_shift_funct(input logic [FUNCT_W-1:0] funct);
        return funct[FUNCT_W-1:2] == 4'b0000;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported functs.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [ALU_W-1:0]   alu_control_c,
    output logic               illegal_c
);

    always_comb begin
        alu_control_c = ALU_ADD;
        illegal_c     = 1'b0;
        case (funct_i)
            FN_SLL:  alu_control_c = ALU_SLL;
            FN_SRL:  alu_control_c = ALU_SRL;
            FN_SRA:  alu_control_c = ALU_SRA;
            FN_ADD:  alu_control_c = ALU_ADD;
            FN_SUB:  alu_control_c = ALU_SUB;
            FN_AND:  alu_control_c = ALU_AND;
            FN_OR:   alu_control_c = ALU_OR;
            FN_SLT:  alu_control_c = ALU_SLT;
            default: illegal_c     = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS sequencer: per-state control word for the shared ALU, unified
// memory port and register file, with request/ready memory wait states.
module mc_control_fsm
    import mc_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic               equal_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_write_o,
    output logic               i_or_d_o,
    output logic               ir_write_o,
    output logic               pc_en_o,
    output logic [SEL_W-1:0]   pc_src_o,
    output logic [SEL_W-1:0]   alu_src_a_o,
    output logic [SEL_W-1:0]   alu_src_b_o,
    output logic [ALU_W-1:0]   alu_control_o,
    output logic               sign_o,
    output logic               reg_write_o,
    output logic [SEL_W-1:0]   reg_dst_o,
    output logic [SEL_W-1:0]   mem_to_reg_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    state_e           state;
    state_e           state_next;
    logic [ALU_W-1:0] r_alu_control;
    logic             r_illegal;

    mc_alu_dec u_alu_dec (
        .funct_i       (funct_i),
        .alu_control_c (r_alu_control),
        .illegal_c     (r_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    assign state_o = STATE_W'(state);

    always_comb begin
        state_next    = state;
        mem_req_o     = 1'b0;
        mem_write_o   = 1'b0;
        i_or_d_o      = 1'b0;
        ir_write_o    = 1'b0;
        pc_en_o       = 1'b0;
        pc_src_o      = PC_SRC_ALU;
        alu_src_a_o   = SRC_A_PC;
        alu_src_b_o   = SRC_B_REGB;
        alu_control_o = ALU_ADD;
        sign_o        = 1'b0;
        reg_write_o   = 1'b0;
        reg_dst_o     = REG_DST_RT;
        mem_to_reg_o  = M2R_ALUOUT;
        illegal_o     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_a_o = SRC_A_PC;
                alu_src_b_o = SRC_B_FOUR;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_en_o    = 1'b1;
                    pc_src_o   = PC_SRC_ALU;
                    state_next = S_DECODE;
                end
            end
            // Branch target is computed speculatively while the opcode is decoded.
            S_DECODE: begin
                alu_src_a_o = SRC_A_PC;
                alu_src_b_o = SRC_B_IMM_SL2;
                sign_o      = 1'b1;
                case (op_i)
                    OP_LW, OP_SW:     state_next = S_MEM_ADR;
                    OP_RTYPE:         state_next = (funct_i == FN_JR) ? S_JR : S_R_EXEC;
                    OP_J:             state_next = S_JUMP;
                    OP_JAL:           state_next = S_JAL;
                    OP_BEQ, OP_BNE:   state_next = S_BRANCH;
                    OP_ADDI, OP_SLTI,
                    OP_ANDI, OP_ORI:  state_next = S_I_EXEC;
                    default: begin
                        illegal_o  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a_o = SRC_A_REGA;
                alu_src_b_o = SRC_B_IMM;
                sign_o      = 1'b1;
                state_next  = (op_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req_o = 1'b1;
                i_or_d_o  = 1'b1;
                if (mem_ready_i) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = REG_DST_RT;
                mem_to_reg_o = M2R_MEM;
                state_next   = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                if (mem_ready_i) state_next = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a_o   = is_shift_funct(funct_i) ? SRC_A_SHAMT : SRC_A_REGA;
                alu_src_b_o   = SRC_B_REGB;
                alu_control_o = r_alu_control;
                if (r_illegal) begin
                    illegal_o  = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_ALU_WB;
                end
            end
            S_ALU_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = REG_DST_RD;
                mem_to_reg_o = M2R_ALUOUT;
                state_next   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a_o = SRC_A_REGA;
                alu_src_b_o = SRC_B_IMM;
                case (op_i)
                    OP_SLTI: begin
                        alu_control_o = ALU_SLT;
                        sign_o        = 1'b1;
                    end
                    OP_ANDI: alu_control_o = ALU_AND;
                    OP_ORI:  alu_control_o = ALU_OR;
                    default: begin
                        alu_control_o = ALU_ADD;
                        sign_o        = 1'b1;
                    end
                endcase
                state_next = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = REG_DST_RT;
                mem_to_reg_o = M2R_ALUOUT;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o   = SRC_A_REGA;
                alu_src_b_o   = SRC_B_REGB;
                alu_control_o = ALU_SUB;
                pc_src_o      = PC_SRC_ALUOUT;
                pc_en_o       = (op_i == OP_BEQ) ? equal_i : !equal_i;
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_src_o   = PC_SRC_JUMP;
                pc_en_o    = 1'b1;
                state_next = S_FETCH;
            end
            // PC already holds PC+4 here, so it is the link value.
            S_JAL: begin
                pc_src_o     = PC_SRC_JUMP;
                pc_en_o      = 1'b1;
                reg_write_o  = 1'b1;
                reg_dst_o    = REG_DST_RA;
                mem_to_reg_o = M2R_PC;
                state_next   = S_FETCH;
            end
            S_JR: begin
                pc_src_o   = PC_SRC_REGA;
                pc_en_o    = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset abandons any access and suppresses every side effect.
        if (rst_i) begin
            mem_req_o   = 1'b0;
            mem_write_o = 1'b0;
            ir_write_o  = 1'b0;
            pc_en_o     = 1'b0;
            reg_write_o = 1'b0;
            illegal_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: each instruction expands into its expected per-cycle control
// timeline (including memory wait cycles), which is replayed against the DUT.
module tb_mc_control_fsm;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [5:0] op_i, funct_i;
    logic       equal_i, mem_ready_i;
    logic       mem_req_o, mem_write_o, i_or_d_o, ir_write_o, pc_en_o;
    logic [1:0] pc_src_o, alu_src_a_o, alu_src_b_o, reg_dst_o, mem_to_reg_o;
    logic [3:0] alu_control_o, state_o;
    logic       sign_o, reg_write_o, illegal_o;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .funct_i(funct_i),
        .equal_i(equal_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .i_or_d_o(i_or_d_o),
        .ir_write_o(ir_write_o), .pc_en_o(pc_en_o), .pc_src_o(pc_src_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_control_o(alu_control_o), .sign_o(sign_o), .reg_write_o(reg_write_o),
        .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .illegal_o(illegal_o),
        .state_o(state_o)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req, mem_write, i_or_d, ir_write, pc_en;
        logic [1:0] pc_src, src_a, src_b;
        logic [3:0] alu;
        logic       sign, reg_write;
        logic [1:0] reg_dst, m2r;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        ctl_t       exp;
        logic       rdy;
        logic [5:0] op;
        logic [5:0] fn;
        logic       eq;
    } step_t;

    typedef enum {CL_LW, CL_SW, CL_R, CL_JR, CL_J, CL_JAL, CL_BR, CL_I, CL_ILL} cls_e;

    ctl_t  obs;
    step_t q[$];
    int    errors = 0;
    int    checks = 0;

    assign obs = {state_o, mem_req_o, mem_write_o, i_or_d_o, ir_write_o, pc_en_o,
                  pc_src_o, alu_src_a_o, alu_src_b_o, alu_control_o, sign_o,
                  reg_write_o, reg_dst_o, mem_to_reg_o, illegal_o};

    function automatic ctl_t base(input state_e s);
        ctl_t c;
        c       = '0;
        c.state = 4'(s);
        c.alu   = 4'd2;
        return c;
    endfunction

    function automatic cls_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23:                      return CL_LW;
            6'h2b:                      return CL_SW;
            6'h00:                      return (fn == 6'h08) ? CL_JR : CL_R;
            6'h02:                      return CL_J;
            6'h03:                      return CL_JAL;
            6'h04, 6'h05:               return CL_BR;
            6'h08, 6'h0a, 6'h0c, 6'h0d: return CL_I;
            default:                    return CL_ILL;
        endcase
    endfunction

    function automatic void r_alu(input logic [5:0] fn, output logic ok, output logic [3:0] alu);
        ok = 1'b1;
        case (fn)
            6'h00:   alu = 4'd3;
            6'h02:   alu = 4'd8;
            6'h03:   alu = 4'd9;
            6'h20:   alu = 4'd2;
            6'h22:   alu = 4'd6;
            6'h24:   alu = 4'd0;
            6'h25:   alu = 4'd1;
            6'h2a:   alu = 4'd7;
            default: begin ok = 1'b0; alu = 4'd2; end
        endcase
    endfunction

    task automatic push(input ctl_t c, input logic r, input logic [5:0] o,
                        input logic [5:0] f, input logic e);
        step_t s;
        s.exp = c; s.rdy = r; s.op = o; s.fn = f; s.eq = e;
        q.push_back(s);
    endtask

    task automatic check(input ctl_t e, input string tag);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: state got %0d want %0d, ctl got %h want %h",
                   tag, obs.state, e.state, obs, e);
        end
    endtask

    // Expected timeline of one instruction; fw/mw = wait cycles in fetch/memory.
    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                             input int fw, input int mw);
        ctl_t c;
        cls_e cl;
        logic ok;
        logic [3:0] alu;
        for (int i = 0; i <= fw; i++) begin
            c = base(S_FETCH); c.mem_req = 1'b1; c.src_b = 2'd1;
            if (i == fw) begin c.ir_write = 1'b1; c.pc_en = 1'b1; end
            push(c, 1'(i == fw), 6'($urandom), 6'($urandom), eq);
        end
        cl = classify(op, fn);
        c = base(S_DECODE); c.src_b = 2'd3; c.sign = 1'b1; c.illegal = 1'(cl == CL_ILL);
        push(c, 1'($urandom), op, fn, eq);
        case (cl)
            CL_LW, CL_SW: begin
                c = base(S_MEM_ADR); c.src_a = 2'd1; c.src_b = 2'd2; c.sign = 1'b1;
                push(c, 1'($urandom), op, fn, eq);
                for (int i = 0; i <= mw; i++) begin
                    c = base(cl == CL_LW ? S_MEM_READ : S_MEM_WRITE);
                    c.mem_req = 1'b1; c.i_or_d = 1'b1; c.mem_write = 1'(cl == CL_SW);
                    push(c, 1'(i == mw), op, fn, eq);
                end
                if (cl == CL_LW) begin
                    c = base(S_MEM_WB); c.reg_write = 1'b1; c.m2r = 2'd1;
                    push(c, 1'($urandom), op, fn, eq);
                end
            end
            CL_R: begin
                r_alu(fn, ok, alu);
                c = base(S_R_EXEC); c.src_a = (fn < 6'd4) ? 2'd2 : 2'd1;
                c.alu = alu; c.illegal = !ok;
                push(c, 1'($urandom), op, fn, eq);
                if (ok) begin
                    c = base(S_ALU_WB); c.reg_write = 1'b1; c.reg_dst = 2'd1;
                    push(c, 1'($urandom), op, fn, eq);
                end
            end
            CL_JR: begin
                c = base(S_JR); c.pc_src = 2'd3; c.pc_en = 1'b1;
                push(c, 1'($urandom), op, fn, eq);
            end
            CL_J: begin
                c = base(S_JUMP); c.pc_src = 2'd2; c.pc_en = 1'b1;
                push(c, 1'($urandom), op, fn, eq);
            end
            CL_JAL: begin
                c = base(S_JAL); c.pc_src = 2'd2; c.pc_en = 1'b1; c.reg_write = 1'b1;
                c.reg_dst = 2'd2; c.m2r = 2'd2;
                push(c, 1'($urandom), op, fn, eq);
            end
            CL_BR: begin
                c = base(S_BRANCH); c.src_a = 2'd1; c.alu = 4'd6; c.pc_src = 2'd1;
                c.pc_en = (op == 6'h04) ? eq : !eq;
                push(c, 1'($urandom), op, fn, eq);
            end
            CL_I: begin
                c = base(S_I_EXEC); c.src_a = 2'd1; c.src_b = 2'd2;
                case (op)
                    6'h0a:   begin c.alu = 4'd7; c.sign = 1'b1; end
                    6'h0c:   c.alu = 4'd0;
                    6'h0d:   c.alu = 4'd1;
                    default: begin c.alu = 4'd2; c.sign = 1'b1; end
                endcase
                push(c, 1'($urandom), op, fn, eq);
                c = base(S_IMM_WB); c.reg_write = 1'b1;
                push(c, 1'($urandom), op, fn, eq);
            end
            default: ;
        endcase
    endtask

    task automatic run(input string tag);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            mem_ready_i = s.rdy; op_i = s.op; funct_i = s.fn; equal_i = s.eq;
            #1;
            check(s.exp, tag);
        end
    endtask

    logic [5:0] op_pool [13];
    logic [5:0] fn_pool [10];
    ctl_t       c;
    logic [5:0] rop, rfn;

    initial begin
        op_pool = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                    6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h3f};
        fn_pool = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h01};
        rst_i = 1'b1; mem_ready_i = 1'b1; op_i = '0; funct_i = '0; equal_i = 1'b0;

        // Held reset: FETCH, no request and no IR/PC write even with ready high.
        @(negedge clk); #1;
        c = base(S_FETCH); c.src_b = 2'd1;
        check(c, "reset_state");

        @(negedge clk);
        rst_i = 1'b0; mem_ready_i = 1'b0; #1;
        c.mem_req = 1'b1;
        check(c, "first_fetch");

        add_instr(6'h23, 6'h00, 1'b0, 0, 0); run("lw_nowait");
        add_instr(6'h08, 6'h00, 1'b0, 3, 0); run("fetch_wait3_addi");
        add_instr(6'h04, 6'h00, 1'b1, 0, 0); run("beq_taken");
        add_instr(6'h05, 6'h00, 1'b1, 0, 0); run("bne_not_taken");
        add_instr(6'h04, 6'h00, 1'b0, 0, 0); run("beq_not_taken");
        add_instr(6'h05, 6'h00, 1'b0, 0, 0); run("bne_taken");
        add_instr(6'h03, 6'h00, 1'b0, 0, 0); run("jal");
        add_instr(6'h00, 6'h00, 1'b0, 0, 0); run("sll");
        add_instr(6'h3f, 6'h00, 1'b0, 0, 0); run("illegal_op");
        add_instr(6'h00, 6'h3f, 1'b0, 0, 0); run("illegal_funct");
        add_instr(6'h00, 6'h01, 1'b0, 0, 0); run("illegal_shift_funct");
        add_instr(6'h2b, 6'h00, 1'b0, 0, 2); run("sw_wait2");
        add_instr(6'h23, 6'h00, 1'b0, 1, 3); run("lw_wait3");
        add_instr(6'h00, 6'h08, 1'b0, 0, 0); run("jr");
        add_instr(6'h02, 6'h00, 1'b0, 0, 0); run("j");
        add_instr(6'h0a, 6'h00, 1'b0, 0, 0); run("slti");
        add_instr(6'h0c, 6'h00, 1'b0, 0, 0); run("andi");
        add_instr(6'h0d, 6'h00, 1'b0, 0, 0); run("ori");
        for (int i = 0; i < 9; i++) begin
            add_instr(6'h00, fn_pool[i], 1'b0, 0, 0); run("rtype_table");
        end

        // Reset during a MEM_WRITE wait: access dropped, refetch from PC.
        add_instr(6'h2b, 6'h00, 1'b0, 0, 5);
        while (q.size() > 4) void'(q.pop_back());
        run("sw_before_reset");
        @(negedge clk);
        rst_i = 1'b1; mem_ready_i = 1'b0; #1;
        c = base(S_MEM_WRITE); c.i_or_d = 1'b1;
        check(c, "reset_in_mem_write");
        @(negedge clk); #1;
        c = base(S_FETCH); c.src_b = 2'd1;
        check(c, "reset_to_fetch");
        @(negedge clk);
        rst_i = 1'b0; #1;
        c.mem_req = 1'b1;
        check(c, "refetch_after_reset");

        for (int n = 0; n < 200; n++) begin
            rop = op_pool[$urandom_range(0, 12)];
            if (rop == 6'h3f) rop = 6'($urandom);
            rfn = fn_pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) rfn = 6'($urandom);
            add_instr(rop, rfn, 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
            run("random");
        end

        c = base(S_FETCH); c.mem_req = 1'b1; c.src_b = 2'd1;
        push(c, 1'b0, 6'h00, 6'h00, 1'b0);
        run("final_fetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle sequencer for the MIPS datapath. It drives one shared ALU, one unified instruction/data memory port and the register file across several cycles per instruction. It decodes the instruction register's opcode and funct fields into a per-state control word and handles memory wait states through a request/ready handshake. It sits between the instruction register and the multicycle datapath, replacing the single-cycle decoder in the multicycle build.

## Interface
Parameters:
- none; all encodings come from `mc_pkg`.

Ports (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- op_i  in  6  opcode from the instruction register.
- funct_i  in  6  funct field from the instruction register.
- equal_i  in  1  register A equals register B (datapath comparator).
- mem_ready_i  in  1  memory completes the current access this cycle.
- mem_req_o  out  1  memory access request.
- mem_write_o  out  1  write access (valid only with mem_req_o).
- i_or_d_o  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write_o  out  1  load the instruction register.
- pc_en_o  out  1  PC write enable.
- pc_src_o  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- alu_src_a_o  out  2  ALU A select: 00 = PC, 01 = register A, 10 = zero-extended shamt.
- alu_src_b_o  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = immediate shifted left by 2.
- alu_control_o  out  4  ALU operation: 0 AND, 1 OR, 2 ADD, 3 SLL, 6 SUB, 7 SLT, 8 SRL, 9 SRA.
- sign_o  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- reg_write_o  out  1  register file write enable.
- reg_dst_o  out  2  destination register: 00 = rt, 01 = rd, 10 = r31.
- mem_to_reg_o  out  2  write-back source: 00 = ALUOut, 01 = memory data, 10 = PC.
- illegal_o  out  1  one-cycle pulse on an unsupported op or funct.
- state_o  out  4  current state, for debug only.

## Operation
- The state register is the only storage. Outputs are decoded from the state, op_i and funct_i. ir_write_o and pc_en_o additionally depend on mem_ready_i and equal_i, as listed per state.
- Default for every output not named in a state: 0. alu_control_o defaults to 2 (ADD).

States and transitions:
- FETCH: mem_req_o=1; ALU computes PC+4 (src_a 00, src_b 01, ADD).
  - If mem_ready_i: ir_write_o=1, pc_en_o=1 (pc_src 00), go to DECODE.
  - Otherwise stay in FETCH with ir_write_o=0 and pc_en_o=0.
- DECODE: ALU computes the branch target (src_a 00, src_b 11, ADD, sign_o=1). Next state by instruction:
  - LW, SW → MEM_ADR.
  - R-type → R_EXEC.
  - JR (op 0, funct 001000) → JR.
  - J → JUMP.
  - JAL → JAL.
  - BEQ, BNE → BRANCH.
  - ADDI, SLTI, ANDI, ORI → I_EXEC.
  - Anything else → FETCH with illegal_o=1.
- MEM_ADR: src_a 01, src_b 10, ADD, sign_o=1. LW → MEM_READ; SW → MEM_WRITE.
- MEM_READ: mem_req_o=1, i_or_d_o=1. Hold until mem_ready_i, then → MEM_WB.
- MEM_WB: reg_write_o=1, reg_dst 00, mem_to_reg 01. → FETCH.
- MEM_WRITE: mem_req_o=1, mem_write_o=1, i_or_d_o=1. Hold until mem_ready_i, then → FETCH.
- R_EXEC: src_b 00; alu_control from funct. → ALU_WB.
  - Shift funct (0000??): src_a 10.
  - Other funct: src_a 01.
  - Unsupported funct: illegal_o=1, → FETCH with no write-back.
- ALU_WB: reg_write_o=1, reg_dst 01, mem_to_reg 00. → FETCH.
- I_EXEC: src_a 01, src_b 10. → IMM_WB.
  - ADDI: ADD, sign_o=1.
  - SLTI: SLT, sign_o=1.
  - ANDI: AND, sign_o=0.
  - ORI: OR, sign_o=0.
- IMM_WB: reg_write_o=1, reg_dst 00, mem_to_reg 00. → FETCH.
- BRANCH: src_a 01, src_b 00, SUB, pc_src 01. pc_en_o = equal_i for BEQ, !equal_i for BNE. → FETCH.
- JUMP: pc_src 10, pc_en_o=1. → FETCH.
- JAL: pc_src 10, pc_en_o=1, reg_write_o=1, reg_dst 10, mem_to_reg 10 (PC already holds PC+4). → FETCH.
- JR: pc_src 11, pc_en_o=1. → FETCH.

## Timing
- Reset: state becomes FETCH at the first clock edge with rst_i=1. While rst_i=1, all enables, mem_req_o and illegal_o are forced to 0. The first fetch request appears in the first cycle after rst_i falls.
- Reset mid-access: the outstanding request is abandoned with no PC, IR or register write. Memory must tolerate a dropped request.
- Cycles per instruction with zero wait states:
  - LW: 5.
  - SW, R-type, I-type: 4.
  - BEQ, BNE, J, JAL, JR: 3.
  - Illegal: 2.
- Each cycle with mem_ready_i=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- Handshake: mem_req_o and its address select stay stable until the cycle mem_ready_i=1. mem_ready_i is ignored in all other states.
- op_i and funct_i are sampled only in DECODE and later states, because the instruction register is stable after FETCH.

## Structure
- `mc_pkg` holds:
  - the state_e enum (4-bit);
  - opcode and funct constants;
  - ALU control constants;
  - pc_src, alu_src_a, alu_src_b, reg_dst and mem_to_reg encodings.
- Sub-module `mc_alu_dec`: combinational funct → alu_control_o plus an illegal flag. It is used in R_EXEC.

## Test plan
- Reset then LW with mem_ready_i=1 always: states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, FETCH; reg_write_o=1 only in cycle 5 with mem_to_reg 01 and reg_dst 00.
- FETCH with 3 wait cycles: mem_req_o=1 held for 4 cycles; ir_write_o and pc_en_o pulse only in the 4th.
- BEQ with equal_i=1 gives pc_en_o=1 and pc_src 01; BNE with equal_i=1 gives pc_en_o=0; both return to FETCH at cycle 3.
- JAL: reg_write_o=1, reg_dst 10, mem_to_reg 10, pc_src 10 in the same cycle. SLL: alu_src_a 10, alu_control 3.
- op 6'b111111, then R-type funct 6'b111111: illegal_o pulses once each, reg_write_o never asserts, and the FSM returns to FETCH.
- rst_i asserted during a MEM_WRITE wait: next cycle state FETCH with mem_write_o=0; after rst_i falls, mem_req_o=1 and i_or_d_o=0.
